// File: rtl/tmr_majority_voter_if.sv
// ---------------------------------------------------------------------------
// tmr_majority_voter_if : sample/result bundle for the TMR majority voter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tmr_majority_voter_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             valid_in;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             clear_faults;
  logic             valid_out;
  logic [WIDTH-1:0] result;
  logic [2:0]       dissent;
  logic             dmr_mismatch;
  logic [2:0]       faulty;
  logic [1:0]       mode;
  logic [CNT_W-1:0] err_cnt_x;
  logic [CNT_W-1:0] err_cnt_y;
  logic [CNT_W-1:0] err_cnt_z;

  modport master (
    output valid_in, x, y, z, clear_faults,
    input  valid_out, result, dissent, dmr_mismatch, faulty, mode,
           err_cnt_x, err_cnt_y, err_cnt_z
  );

  modport slave (
    input  valid_in, x, y, z, clear_faults,
    output valid_out, result, dissent, dmr_mismatch, faulty, mode,
           err_cnt_x, err_cnt_y, err_cnt_z
  );
endinterface

`default_nettype wire

// File: rtl/tmr_majority_voter.sv
// ---------------------------------------------------------------------------
// tmr_majority_voter : registered TMR voter with per-channel fault retirement
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tmr_majority_voter #(
  parameter int WIDTH        = 1,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  tmr_majority_voter_if.slave       bus
);

  typedef enum logic [1:0] {
    S_HEALTHY = 2'd0,
    S_SUSPECT = 2'd1,
    S_FAULTY  = 2'd2
  } ch_state_e;

  localparam logic [1:0] MODE_TMR     = 2'd0;
  localparam logic [1:0] MODE_DMR     = 2'd1;
  localparam logic [1:0] MODE_SIMPLEX = 2'd2;
  localparam logic [1:0] MODE_FAILED  = 2'd3;
  localparam logic [3:0] THRESH       = 4'(FAULT_THRESH);

  logic [WIDTH-1:0] word [3];
  logic [2:0]       faulty;
  logic [1:0]       mode;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] vote;
  logic             mism;
  logic [2:0]       dissent_n;
  logic [CNT_W-1:0] err_cnt [3];

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       dissent_q;
  logic             mism_q;

  assign word[0] = bus.x;
  assign word[1] = bus.y;
  assign word[2] = bus.z;

  always_comb begin
    mode = MODE_SIMPLEX;
    case (faulty)
      3'b000:                 mode = MODE_TMR;
      3'b001, 3'b010, 3'b100: mode = MODE_DMR;
      3'b111:                 mode = MODE_FAILED;
      default:                mode = MODE_SIMPLEX;
    endcase
  end

  // Mode comes from the registered fault flags, so a sample is always voted
  // with the configuration that existed before its own edge.
  always_comb begin
    maj  = (word[0] & word[1]) | (word[1] & word[2]) | (word[0] & word[2]);
    vote = maj;
    mism = 1'b0;
    case (mode)
      MODE_DMR: begin
        if (faulty[0]) begin
          vote = word[1];
          mism = (word[1] != word[2]);
        end else if (faulty[1]) begin
          vote = word[0];
          mism = (word[0] != word[2]);
        end else begin
          vote = word[0];
          mism = (word[0] != word[1]);
        end
      end
      MODE_SIMPLEX: begin
        if (!faulty[0])      vote = word[0];
        else if (!faulty[1]) vote = word[1];
        else                 vote = word[2];
      end
      default: vote = maj;
    endcase
  end

  always_comb begin
    dissent_n = 3'b000;
    for (int c = 0; c < 3; c++) begin
      dissent_n[c] = (word[c] != vote);
    end
  end

  generate
    for (genvar c = 0; c < 3; c++) begin : g_ch
      ch_state_e  state;
      ch_state_e  state_n;
      logic [3:0] consec;
      logic [3:0] consec_n;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state  <= S_HEALTHY;
          consec <= 4'd0;
        end else begin
          state  <= state_n;
          consec <= consec_n;
        end
      end

      // Consecutive tracking only in TMR; elsewhere attribution is unreliable.
      always_comb begin
        state_n  = state;
        consec_n = consec;
        if (bus.clear_faults) begin
          state_n  = S_HEALTHY;
          consec_n = 4'd0;
        end else if (bus.valid_in && (mode == MODE_TMR)) begin
          if (dissent_n[c]) begin
            consec_n = consec + 4'd1;
            state_n  = (consec_n >= THRESH) ? S_FAULTY : S_SUSPECT;
          end else begin
            consec_n = 4'd0;
            state_n  = S_HEALTHY;
          end
        end
      end

      assign faulty[c] = (state == S_FAULTY);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_cnt[c] <= '0;
        end else if (bus.valid_in && dissent_n[c] && (err_cnt[c] != '1)) begin
          err_cnt[c] <= err_cnt[c] + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      dissent_q <= 3'b000;
      mism_q    <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      mism_q  <= bus.valid_in & mism;
      if (bus.valid_in) begin
        result_q  <= vote;
        dissent_q <= dissent_n;
      end
    end
  end

  assign bus.valid_out    = valid_q;
  assign bus.result       = result_q;
  assign bus.dissent      = dissent_q;
  assign bus.dmr_mismatch = mism_q;
  assign bus.faulty       = faulty;
  assign bus.mode         = mode;
  assign bus.err_cnt_x    = err_cnt[0];
  assign bus.err_cnt_y    = err_cnt[1];
  assign bus.err_cnt_z    = err_cnt[2];

endmodule

`default_nettype wire

// File: tb/tb_tmr_majority_voter.sv
// ---------------------------------------------------------------------------
// tb_tmr_majority_voter : directed scoreboard bench for tmr_majority_voter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tmr_majority_voter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tmr_majority_voter_if #(.WIDTH(4), .CNT_W(8)) ifa ();
  tmr_majority_voter_if #(.WIDTH(1), .CNT_W(2)) ifb ();

  tmr_majority_voter #(.WIDTH(4), .FAULT_THRESH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  tmr_majority_voter #(.WIDTH(1), .FAULT_THRESH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct {
    string      tag;
    logic       vout;
    logic [3:0] result;
    logic [2:0] dissent;
    logic       mism;
    logic [2:0] faulty;
    logic [1:0] mode;
    logic [7:0] cnt [3];
  } exp_t;

  exp_t sb [$];

  logic [2:0] m_faulty;
  int         m_consec [3];
  int         m_cnt [3];
  logic [3:0] m_result;
  logic [2:0] m_dissent;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pop3(logic [2:0] f);
    return 2'(int'(f[0]) + int'(f[1]) + int'(f[2]));
  endfunction

  task automatic model_reset();
    m_faulty  = 3'b000;
    m_result  = 4'h0;
    m_dissent = 3'b000;
    for (int c = 0; c < 3; c++) begin
      m_consec[c] = 0;
      m_cnt[c]    = 0;
    end
    sb.delete();
  endtask

  task automatic drive_a(string tag, logic v, logic [3:0] xv, logic [3:0] yv,
                         logic [3:0] zv, logic clr);
    exp_t       e;
    logic [3:0] w [3];
    logic [3:0] vote;
    logic       mism;
    logic [1:0] md;
    int         first;
    int         second;
    w[0] = xv; w[1] = yv; w[2] = zv;
    md   = pop3(m_faulty);
    vote = (xv & yv) | (yv & zv) | (xv & zv);
    mism = 1'b0;
    if (md == 2'd1 || md == 2'd2) begin
      first = -1; second = -1;
      for (int c = 0; c < 3; c++) begin
        if (!m_faulty[c]) begin
          if (first < 0) first = c;
          else second = c;
        end
      end
      vote = w[first];
      if (md == 2'd1) mism = (w[first] != w[second]);
    end
    if (v) begin
      m_result = vote;
      for (int c = 0; c < 3; c++) begin
        m_dissent[c] = (w[c] != vote);
        if (m_dissent[c] && m_cnt[c] < 255) m_cnt[c]++;
      end
    end
    if (clr) begin
      m_faulty = 3'b000;
      for (int c = 0; c < 3; c++) m_consec[c] = 0;
    end else if (v && md == 2'd0) begin
      for (int c = 0; c < 3; c++) begin
        if (m_dissent[c]) begin
          m_consec[c]++;
          if (m_consec[c] >= 4) m_faulty[c] = 1'b1;
        end else begin
          m_consec[c] = 0;
        end
      end
    end
    e.tag = tag; e.vout = v; e.result = m_result; e.dissent = m_dissent;
    e.mism = v & mism; e.faulty = m_faulty; e.mode = pop3(m_faulty);
    for (int c = 0; c < 3; c++) e.cnt[c] = 8'(m_cnt[c]);
    sb.push_back(e);

    ifa.valid_in = v; ifa.x = xv; ifa.y = yv; ifa.z = zv; ifa.clear_faults = clr;
    @(posedge clk);
    #1;
    ifa.valid_in = 1'b0; ifa.clear_faults = 1'b0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".valid_out"}, 32'(ifa.valid_out), 32'(e.vout));
      chk({e.tag, ".result"},    32'(ifa.result),    32'(e.result));
      chk({e.tag, ".dissent"},   32'(ifa.dissent),   32'(e.dissent));
      chk({e.tag, ".dmr_mism"},  32'(ifa.dmr_mismatch), 32'(e.mism));
      chk({e.tag, ".faulty"},    32'(ifa.faulty),    32'(e.faulty));
      chk({e.tag, ".mode"},      32'(ifa.mode),      32'(e.mode));
      chk({e.tag, ".cnt_x"},     32'(ifa.err_cnt_x), 32'(e.cnt[0]));
      chk({e.tag, ".cnt_y"},     32'(ifa.err_cnt_y), 32'(e.cnt[1]));
      chk({e.tag, ".cnt_z"},     32'(ifa.err_cnt_z), 32'(e.cnt[2]));
    end
  endtask

  task automatic drive_b(logic v, logic xv, logic yv, logic zv);
    ifb.valid_in = v; ifb.x = xv; ifb.y = yv; ifb.z = zv;
    @(posedge clk);
    #1;
    ifb.valid_in = 1'b0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".a_vout"},   32'(ifa.valid_out), 0);
    chk({tag, ".a_result"}, 32'(ifa.result), 0);
    chk({tag, ".a_dissent"}, 32'(ifa.dissent), 0);
    chk({tag, ".a_mism"},   32'(ifa.dmr_mismatch), 0);
    chk({tag, ".a_faulty"}, 32'(ifa.faulty), 0);
    chk({tag, ".a_mode"},   32'(ifa.mode), 0);
    chk({tag, ".a_cnts"},   32'({ifa.err_cnt_x, ifa.err_cnt_y, ifa.err_cnt_z}), 0);
    chk({tag, ".b_state"},  32'({ifb.valid_out, ifb.result, ifb.faulty, ifb.mode}), 0);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #2;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] xv, yv, zv;
    ifa.valid_in = 1'b0; ifa.x = '0; ifa.y = '0; ifa.z = '0; ifa.clear_faults = 1'b0;
    ifb.valid_in = 1'b0; ifb.x = '0; ifb.y = '0; ifb.z = '0; ifb.clear_faults = 1'b0;
    #1;
    do_reset("reset");

    // exhaustive patterns, each bit lane carries the same 1-bit vote
    for (int i = 0; i < 8; i++) begin
      xv = i[0] ? 4'hF : 4'h0;
      yv = i[1] ? 4'hF : 4'h0;
      zv = i[2] ? 4'hF : 4'h0;
      drive_a($sformatf("pat%0d", i), 1'b1, xv, yv, zv, 1'b0);
      if (i == 5) begin
        chk("ex101.result", 32'(ifa.result), 32'hF);
        chk("ex101.dissent", 32'(ifa.dissent), 32'b010);
      end
    end
    drive_a("idle_hold", 1'b0, 4'h0, 4'hF, 4'h0, 1'b0);

    do_reset("reset2");
    for (int i = 0; i < 4; i++) drive_a($sformatf("ydis%0d", i), 1'b1, 4'h0, 4'hF, 4'h0, 1'b0);
    chk("thresh4.faulty", 32'(ifa.faulty), 32'b010);
    chk("thresh4.mode", 32'(ifa.mode), 1);
    chk("thresh4.cnt_y", 32'(ifa.err_cnt_y), 4);

    do_reset("reset3");
    for (int i = 0; i < 3; i++) drive_a("ydisA", 1'b1, 4'h0, 4'hF, 4'h0, 1'b0);
    drive_a("yagree", 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive_a("ydisB", 1'b1, 4'h0, 4'hF, 4'h0, 1'b0);
    chk("broken_run.faulty", 32'(ifa.faulty), 0);
    chk("broken_run.cnt_y", 32'(ifa.err_cnt_y), 6);
    drive_a("ydis4th", 1'b1, 4'h0, 4'hF, 4'h0, 1'b0);

    for (int i = 0; i < 5; i++) drive_a($sformatf("dmr%0d", i), 1'b1, 4'hA, 4'h0, 4'h5, 1'b0);
    chk("dmr.result", 32'(ifa.result), 32'hA);
    chk("dmr.mism", 32'(ifa.dmr_mismatch), 1);
    chk("dmr.frozen", 32'(ifa.faulty), 32'b010);
    drive_a("dmr_clear", 1'b1, 4'hA, 4'h0, 4'h5, 1'b1);
    chk("clear.mode", 32'(ifa.mode), 0);
    drive_a("post_clear", 1'b1, 4'hA, 4'h0, 4'h5, 1'b0);

    do_reset("reset4");
    for (int i = 0; i < 4; i++) drive_a($sformatf("all%0d", i), 1'b1, 4'h3, 4'h5, 4'h6, 1'b0);
    chk("all.result", 32'(ifa.result), 32'h7);
    chk("all.faulty", 32'(ifa.faulty), 32'b111);
    chk("all.mode", 32'(ifa.mode), 3);
    drive_a("failed_vote", 1'b1, 4'hC, 4'hC, 4'h1, 1'b0);

    do_reset("reset5");
    drive_b(1'b1, 1'b1, 1'b0, 1'b1);
    chk("b_thresh1.result", 32'(ifb.result), 1);
    chk("b_thresh1.dissent", 32'(ifb.dissent), 32'b010);
    chk("b_thresh1.faulty", 32'(ifb.faulty), 32'b010);
    chk("b_thresh1.mode", 32'(ifb.mode), 1);
    chk("b_thresh1.cnt_y", 32'(ifb.err_cnt_y), 1);
    for (int i = 0; i < 4; i++) drive_b(1'b1, 1'b1, 1'b0, 1'b0);
    chk("b_sat.cnt_y", 32'(ifb.err_cnt_y), 3);
    chk("b_sat.cnt_z", 32'(ifb.err_cnt_z), 3);
    chk("b_sat.mism", 32'(ifb.dmr_mismatch), 1);
    chk("b_sat.faulty", 32'(ifb.faulty), 32'b010);

    // asynchronous reset landing between clock edges
    drive_a("pre_async", 1'b1, 4'h3, 4'h5, 4'h6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_a("after_async", 1'b1, 4'h9, 4'h9, 4'h1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tmr_majority_voter.md
Name: tmr_majority_voter

Overview:
- Sequential triple-modular-redundancy voter that sits downstream of three replicated sources x, y, z.
- Registers a bitwise majority vote of each valid sample.
- Identifies the dissenting (minority) channel or channels and tracks consecutive dissent per channel.
- Retires a channel as faulty after a threshold of consecutive dissents, then degrades TMR -> DMR -> SIMPLEX -> FAILED.

Parameters:
- WIDTH, 1: bits per channel word.
- FAULT_THRESH, 4: consecutive dissenting samples that mark a channel FAULTY; legal range 1..15.
- CNT_W, 8: width of each saturating per-channel error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  x/y/z hold a sample this cycle.
- x  input  WIDTH  channel 0 word.
- y  input  WIDTH  channel 1 word.
- z  input  WIDTH  channel 2 word.
- clear_faults  input  1  one-cycle pulse: return all channels to HEALTHY.
- valid_out  output  1  result/dissent valid, one cycle after valid_in.
- result  output  WIDTH  voted word.
- dissent  output  3  {z,y,x}: channel word != result for this sample.
- dmr_mismatch  output  1  in DMR, the two healthy channels disagreed.
- faulty  output  3  {z,y,x} sticky faulty flags.
- mode  output  2  0=TMR, 1=DMR, 2=SIMPLEX, 3=FAILED.
- err_cnt_x  output  CNT_W  saturating total dissent count, channel 0.
- err_cnt_y  output  CNT_W  saturating total dissent count, channel 1.
- err_cnt_z  output  CNT_W  saturating total dissent count, channel 2.

Behaviour:
- Reset (async, rst_n=0):
  - valid_out, result, dissent, dmr_mismatch, faulty, err_cnt_* = 0.
  - mode = TMR.
  - Channel states HEALTHY; consecutive counters 0.
  - Takes effect immediately, mid-stream included; the first sample after deassertion is voted in TMR.
- Latency:
  - Exactly 1 cycle, registered.
  - valid_out = valid_in delayed one cycle.
  - With valid_in=0: result and dissent hold their previous values, dmr_mismatch = 0, no counter or state change.
- Per-channel FSM: HEALTHY -> SUSPECT -> FAULTY.
  - On a counted dissent: consec += 1; state becomes SUSPECT.
  - When consec reaches FAULT_THRESH on that edge: state becomes FAULTY and the faulty bit sets.
  - On a counted agreement: consec = 0; state becomes HEALTHY.
  - FAULTY is sticky until clear_faults or reset.
- Mode is derived from popcount(faulty): 0 -> TMR, 1 -> DMR, 2 -> SIMPLEX, 3 -> FAILED.
- Voting, using the fault state registered before the edge:
  - TMR: result = (x&y)|(y&z)|(x&z), bitwise.
  - DMR: result = lower-index healthy channel word. dmr_mismatch = 1 if the two healthy words differ.
  - SIMPLEX: result = the single healthy channel word.
  - FAILED: result = bitwise majority of all three; mode = 3 signals the condition.
- dissent[c] = (channel c word != result), computed for all three channels in every mode.
- Counting rules:
  - err_cnt_c increments on every valid sample with dissent[c]=1, in any mode. It saturates at 2^CNT_W-1. Only reset clears it.
  - Consecutive counting (the FSM) runs in TMR mode only. In DMR, attribution is ambiguous, so consec is frozen for all channels.
  - Multiple channels may dissent in one multi-bit sample. All dissenters count, so two channels may go FAULTY on the same edge (TMR -> SIMPLEX directly).
- clear_faults:
  - On the edge it is high: faulty = 0, all consec = 0, all states HEALTHY, mode = TMR next cycle.
  - A sample arriving in the same cycle is voted with the pre-clear mode. Its err_cnt increments apply; its consec updates are discarded.
- Boundary: with FAULT_THRESH=1, a single TMR dissent marks the channel FAULTY on that edge.

Test Plan:
- Reset then WIDTH=1 exhaustive: 8 patterns of x,y,z, valid_in=1 -> result = majority one cycle later. Example: (1,0,1) -> result=1, dissent=3'b010.
- FAULT_THRESH=4: y=~x=~z for 4 consecutive samples -> faulty=3'b010 and mode=1 after the 4th edge, err_cnt_y=4. With 3 dissents, then 1 agreement, then 3 dissents: faulty stays 0 and err_cnt_y=6.
- DMR with y faulty, WIDTH=4: x=4'hA, z=4'h5 -> result=4'hA, dmr_mismatch=1, no consec change, err_cnt_z increments.
- WIDTH=4 in TMR: x=4'h3, y=4'h5, z=4'h6 for 4 samples -> result=4'h7, dissent=3'b111. All three channels go FAULTY on the same edge; mode=3.
- clear_faults pulse coincident with a sample in DMR -> sample voted in DMR, mode=0 next cycle, faulty=0, err_cnt_* unchanged apart from that sample's dissent increments.
- Async reset asserted mid-stream between edges -> all outputs 0 immediately. err_cnt saturation: CNT_W=2 with 5 dissents -> err_cnt=3.
